// File: rtl/cnn_pkg.sv
// Shared CNN layer constants, the default data word type and the pool-stage FSM encoding.
// Also holds the lane-offset helper used to walk a 2x2 window.
package cnn_pkg;

    localparam int CONV1_DIM = 24;
    localparam int POOL1_DIM = CONV1_DIM / 2;
    localparam int WORD_W    = 16;

    typedef logic signed [WORD_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pool_state_e;

    // Lane j of a window sits at base + {0, 1, W, W+1}: top pair, then bottom pair.
    function automatic int lane_offset(input logic [1:0] lane, input int img_w);
        case (lane)
            2'd0:    return 0;
            2'd1:    return 1;
            2'd2:    return img_w;
            default: return img_w + 1;
        endcase
    endfunction

endpackage

// File: rtl/pool1_addr_gen.sv
// Lane/column/row walker over the conv1 map in 2x2 window raster order.
// rd_addr is valid in the same cycle as the counters; holds on the final address once last is reached.
module pool1_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W  = CONV1_DIM,
    parameter int ADDR_W = $clog2(IMG_W * IMG_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        lane,
    output logic              last
);

    localparam int WIN   = IMG_W / 2;
    localparam int CNT_W = (WIN > 1) ? $clog2(WIN) : 1;

    localparam logic [CNT_W-1:0]  COL_MAX  = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0]  ROW_MAX  = CNT_W'(WIN - 1);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(2);
    // Leaving the last column jumps over the bottom row of the window pair.
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W + 2);

    logic [CNT_W-1:0]  col;
    logic [CNT_W-1:0]  row;
    logic [ADDR_W-1:0] base;

    assign last    = (lane == 2'd3) && (col == COL_MAX) && (row == ROW_MAX);
    assign rd_addr = base + ADDR_W'(lane_offset(lane, IMG_W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane <= 2'd0;
            col  <= '0;
            row  <= '0;
            base <= '0;
        end else if (clear) begin
            lane <= 2'd0;
            col  <= '0;
            row  <= '0;
            base <= '0;
        end else if (advance && !last) begin
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
                if (col == COL_MAX) begin
                    col  <= '0;
                    row  <= row + 1'b1;
                    base <= base + ROW_STEP;
                end else begin
                    col  <= col + 1'b1;
                    base <= base + COL_STEP;
                end
            end
        end
    end

endmodule

// File: rtl/pool1_ctrl.sv
// 2x2 signed max-pool sequencer: one conv1 read per cycle, one pool1 write per window (optional POOL1_RELU_EN clamp).
// First write RD_LAT+5 cycles after start is sampled; done RD_LAT+578 cycles after; no backpressure.
module pool1_ctrl
    import cnn_pkg::*;
#(
    parameter int  IMG_W  = CONV1_DIM,
    parameter int  DATA_W = WORD_W,
    parameter int  RD_LAT = 2,
    localparam int RD_AW  = $clog2(IMG_W * IMG_W),
    localparam int WR_AW  = $clog2((IMG_W / 2) * (IMG_W / 2))
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [RD_AW-1:0]         rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     wr_en,
    output logic [WR_AW-1:0]         wr_addr,
    output logic signed [DATA_W-1:0] wr_data
);

    localparam int               N_WIN    = (IMG_W / 2) * (IMG_W / 2);
    localparam logic [WR_AW-1:0] LAST_WIN = WR_AW'(N_WIN - 1);

    pool_state_e state;

    logic        accept;
    logic [1:0]  lane;
    logic        last_rd;

    logic [RD_LAT-1:0] ret_vld;
    logic [RD_LAT-1:0] ret_first;
    logic [RD_LAT-1:0] ret_last;

    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W-1:0] pooled;
    logic signed [DATA_W-1:0] wr_val;
    logic [WR_AW-1:0]         wr_idx;

    assign accept = start && (state == ST_IDLE);

    pool1_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (RD_AW)
    ) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .advance (rd_en),
        .rd_addr (rd_addr),
        .lane    (lane),
        .last    (last_rd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd_en <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ISSUE;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (last_rd) begin
                        state <= ST_DRAIN;
                        rd_en <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // The last window's write is visible here, so done trails it by one cycle.
                    if (wr_en && (wr_addr == LAST_WIN)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Tags ride alongside each read so the returning word knows its lane.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_vld   <= '0;
            ret_first <= '0;
            ret_last  <= '0;
        end else begin
            ret_vld[0]   <= rd_en;
            ret_first[0] <= rd_en && (lane == 2'd0);
            ret_last[0]  <= rd_en && (lane == 2'd3);
            for (int i = 1; i < RD_LAT; i++) begin
                ret_vld[i]   <= ret_vld[i-1];
                ret_first[i] <= ret_first[i-1];
                ret_last[i]  <= ret_last[i-1];
            end
        end
    end

    always_comb begin
        pooled = acc;
        if (ret_first[RD_LAT-1] || (rd_data > acc)) begin
            pooled = rd_data;
        end
    end

`ifdef POOL1_RELU_EN
    assign wr_val = pooled[DATA_W-1] ? '0 : pooled;
`else
    assign wr_val = pooled;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_idx  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                wr_idx <= '0;
            end
            if (ret_vld[RD_LAT-1]) begin
                acc <= pooled;
                if (ret_last[RD_LAT-1]) begin
                    wr_en   <= 1'b1;
                    wr_addr <= wr_idx;
                    wr_data <= wr_val;
                    wr_idx  <= wr_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool1_ctrl.sv
// Bench for pool1_ctrl: instance 0 (RD_LAT=2) runs every sequence; instances 1 and 2 (RD_LAT=1,4) join the ramp pass.
module tb_pool1_ctrl;
    import cnn_pkg::*;

    localparam int NI   = 3;
    localparam int AW   = 10;
    localparam int WAW  = 8;
    localparam int NWIN = 144;
    localparam int NRD  = 576;
    localparam int NV   = 9;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start0 = 1'b0;
    logic start_x = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          busy_a    [NI];
    logic          done_a    [NI];
    logic          rd_en_a   [NI];
    logic          wr_en_a   [NI];
    logic [AW-1:0] rd_addr_a [NI];
    logic [WAW-1:0] wr_addr_a[NI];
    data_t         rd_data_a [NI];
    data_t         wr_data_a [NI];

    data_t mem [NRD];

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        data_t dp [L];
        always @(posedge clk) begin
            dp[0] <= rd_en_a[g] ? mem[rd_addr_a[g]] : 16'sh5A5A;
            for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
        end
        assign rd_data_a[g] = dp[L-1];

        pool1_ctrl #(.IMG_W(24), .DATA_W(16), .RD_LAT(L)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .start   ((g == 0) ? start0 : start_x),
            .busy    (busy_a[g]),
            .done    (done_a[g]),
            .rd_en   (rd_en_a[g]),
            .rd_addr (rd_addr_a[g]),
            .rd_data (rd_data_a[g]),
            .wr_en   (wr_en_a[g]),
            .wr_addr (wr_addr_a[g]),
            .wr_data (wr_data_a[g])
        );
    end

    typedef struct packed {
        logic [WAW-1:0] addr;
        data_t          data;
    } wr_t;

    typedef struct {
        int    win;
        data_t v0, v1, v2, v3;
        data_t ep;
        data_t er;
    } vec_t;

    vec_t vt [NV];
    wr_t  exp_q [NI][$];
    bit   armed [NI];
    int   s = 0;
    int   rd_n = 0;
    int   errors = 0;
    int   checks = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    task automatic check(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic int exp_rd_addr(input int n);
        int k, j, r, c, off;
        k = n / 4; j = n % 4; r = k / 12; c = k % 12;
        off = (j == 0) ? 0 : (j == 1) ? 1 : (j == 2) ? 24 : 25;
        return 48 * r + 2 * c + off;
    endfunction

    function automatic data_t exp_data(input int k, input bit tbl);
        if (tbl) begin
            for (int v = 0; v < NV; v++) begin
                if (vt[v].win == k) begin
`ifdef POOL1_RELU_EN
                    return vt[v].er;
`else
                    return vt[v].ep;
`endif
                end
            end
        end
        return data_t'(48 * (k / 12) + 2 * (k % 12) + 25);
    endfunction

    task automatic load_mem(input bit tbl);
        int b;
        for (int a = 0; a < NRD; a++) mem[a] = data_t'(a);
        if (tbl) begin
            for (int v = 0; v < NV; v++) begin
                b = 48 * (vt[v].win / 12) + 2 * (vt[v].win % 12);
                mem[b]      = vt[v].v0;
                mem[b + 1]  = vt[v].v1;
                mem[b + 24] = vt[v].v2;
                mem[b + 25] = vt[v].v3;
            end
        end
    endtask

    task automatic push_pass(input bit tbl, input bit all);
        wr_t e;
        for (int i = 0; i < NI; i++) begin
            if (i == 0 || all) begin
                exp_q[i].delete();
                armed[i] = 1'b1;
                for (int k = 0; k < NWIN; k++) begin
                    e.addr = WAW'(k);
                    e.data = exp_data(k, tbl);
                    exp_q[i].push_back(e);
                end
            end
        end
        rd_n = 0;
    endtask

    task automatic start_pass(input bit tbl, input bit all);
        @(negedge clk);
        push_pass(tbl, all);
        s = cyc;
        start0 = 1'b1;
        start_x = all;
        @(negedge clk);
        start0 = 1'b0;
        start_x = 1'b0;
    endtask

    task automatic wait_pass();
        for (int t = 0; t < 800 && (armed[0] || armed[1] || armed[2]); t++) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (armed[i]) begin
                check($sformatf("pass_timeout[%0d]", i), 1, 0);
                armed[i] = 1'b0;
            end
        end
    endtask

    task automatic check_zero(input string nm);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s[%0d]", nm, i),
                  longint'({busy_a[i], done_a[i], rd_en_a[i], wr_en_a[i],
                            rd_addr_a[i], wr_addr_a[i], wr_data_a[i]}), 0);
        end
    endtask

    // Scoreboard and timing monitor; cycle index 1 is the cycle after the start-sampling edge.
    always @(negedge clk) begin
        int  idx;
        wr_t e;
        idx = cyc - s;
        for (int i = 0; i < NI; i++) begin
            if (armed[i] && idx == 1) check($sformatf("busy_rise[%0d]", i), busy_a[i], 1);
            if (armed[i] && idx == 577 + lat_of(i)) check($sformatf("busy_last_wr[%0d]", i), busy_a[i], 1);
            if (wr_en_a[i]) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("unexpected_write[%0d] addr", i), longint'(wr_addr_a[i]), -1);
                end else begin
                    e = exp_q[i].pop_front();
                    check($sformatf("wr_addr[%0d]", i), longint'(wr_addr_a[i]), longint'(e.addr));
                    check($sformatf("wr_data[%0d] win %0d", i, e.addr), longint'(wr_data_a[i]), longint'(e.data));
                    check($sformatf("wr_cycle[%0d] win %0d", i, e.addr), idx, 4 * int'(e.addr) + lat_of(i) + 5);
                end
            end
            if (done_a[i]) begin
                check($sformatf("done_expected[%0d]", i), armed[i], 1);
                check($sformatf("done_cycle[%0d]", i), idx, 578 + lat_of(i));
                check($sformatf("writes_left_at_done[%0d]", i), exp_q[i].size(), 0);
                check($sformatf("busy_at_done[%0d]", i), busy_a[i], 0);
                if (i == 0) check("rd_count", rd_n, NRD);
                armed[i] = 1'b0;
            end
        end
        if (rd_en_a[0]) begin
            check($sformatf("rd_cycle n=%0d", rd_n), idx, rd_n + 1);
            check($sformatf("rd_addr n=%0d", rd_n), longint'(rd_addr_a[0]), exp_rd_addr(rd_n));
            rd_n++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0,   -16'sd5,     -16'sd3,     -16'sd100,   -16'sd7,     -16'sd3,     16'sd0};
        vt[1] = '{1,   16'sh7FFF,   16'sh8000,   16'sd0,      16'sd1,      16'sh7FFF,   16'sh7FFF};
        vt[2] = '{2,   16'sh8000,   16'sh8000,   16'sh8000,   16'sh8000,   16'sh8000,   16'sd0};
        vt[3] = '{11,  16'sd5,      16'sd5,      16'sd5,      16'sd5,      16'sd5,      16'sd5};
        vt[4] = '{12,  -16'sd1,     16'sd0,      -16'sd2,     -16'sd3,     16'sd0,      16'sd0};
        vt[5] = '{13,  16'sd1,      16'sd2,      16'sd3,      16'sd4,      16'sd4,      16'sd4};
        vt[6] = '{70,  16'sd100,    -16'sd1,     -16'sd1,     -16'sd1,     16'sd100,    16'sd100};
        vt[7] = '{142, -16'sd2,     -16'sd9,     16'sd7,      -16'sd3,     16'sd7,      16'sd7};
        vt[8] = '{143, 16'sh8000,   16'sh8001,   -16'sd1,     16'sh8000,   -16'sd1,     16'sd0};

        load_mem(1'b0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_hold");
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_zero("idle");
        end

        // Ramp on all three latencies.
        start_pass(1'b0, 1'b1);
        wait_pass();
        check("hold_rd_addr", longint'(rd_addr_a[0]), 575);
        check("hold_wr_addr", longint'(wr_addr_a[0]), 143);
        check("hold_wr_data", longint'(wr_data_a[0]), 575);
        check("hold_rd_en", rd_en_a[0], 0);

        // Table vectors, with a stray start at cycle 100.
        load_mem(1'b1);
        start_pass(1'b1, 1'b0);
        repeat (99) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (479) @(negedge clk);
        check("done_seen_580", done_a[0], 1);
        start0 = 1'b1;
        @(negedge clk);
        check("start_in_done_ignored", busy_a[0], 0);
        push_pass(1'b1, 1'b0);
        s = cyc;
        @(negedge clk);
        start0 = 1'b0;
        check("start_after_done_accepted", busy_a[0], 1);

        // Reset in the middle of that pass.
        repeat (299) @(negedge clk);
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            armed[i] = 1'b0;
            exp_q[i].delete();
        end
        #1;
        check_zero("async_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check_zero("after_reset");

        start_pass(1'b1, 1'b0);
        wait_pass();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
